wddl_capture: RTL and testbench

WDDL_CAPTURE -- requirements
Module: wddl_capture

---
 rtl/wddl_capture.sv | 140 ++++++++++++++
 tb/tb_wddl_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wddl_capture.sv
// WDDL dual-rail capture: sequences precharge/evaluate phases for a WDDL cone and
// decodes the dual-rail word sampled on the last evaluate cycle, flagging rail faults.
module wddl_capture #(
  parameter int WIDTH    = 8,
  parameter int PRE_CYC  = 1,
  parameter int EVAL_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] rail_t_i,
  input  logic [WIDTH-1:0] rail_f_i,
  output logic             prechrg_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             err_illegal_o,
  output logic             err_incomplete_o,
  output logic             err_spacer_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             busy_o
);

  localparam int MAX_CYC = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
  localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [PH_W-1:0] PRE_LAST  = PH_W'(PRE_CYC - 1);
  localparam logic [PH_W-1:0] EVAL_LAST = PH_W'(EVAL_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_EVAL = 2'd2
  } state_t;

  state_t           r_state;
  logic [PH_W-1:0]  r_phase;
  logic             r_prechrg;
  logic             r_busy;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_err_illegal;
  logic             r_err_incomplete;
  logic             r_err_spacer;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_spacer_bad;
  logic w_illegal;
  logic w_incomplete;

  // Per-bit rail classification; (1,1) is illegal, (0,0) means the cone never evaluated.
  assign w_spacer_bad = |(rail_t_i | rail_f_i);
  assign w_illegal    = |(rail_t_i & rail_f_i);
  assign w_incomplete = |(~(rail_t_i | rail_f_i));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= S_IDLE;
      r_phase          <= '0;
      r_prechrg        <= 1'b1;
      r_busy           <= 1'b0;
      r_data           <= '0;
      r_valid          <= 1'b0;
      r_err_illegal    <= 1'b0;
      r_err_incomplete <= 1'b0;
      r_err_spacer     <= 1'b0;
      r_err_cnt        <= '0;
    end else begin
      r_valid          <= 1'b0;
      r_err_illegal    <= 1'b0;
      r_err_incomplete <= 1'b0;
      r_err_spacer     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en_i) begin
            r_state   <= S_PRE;
            r_phase   <= '0;
            r_prechrg <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_PRE: begin
          if (r_phase == PRE_LAST) begin
            r_state   <= S_EVAL;
            r_phase   <= '0;
            r_prechrg <= 1'b0;
            if (w_spacer_bad) begin
              r_err_spacer <= 1'b1;
              r_err_cnt    <= sat_inc(r_err_cnt);
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_EVAL: begin
          if (r_phase == EVAL_LAST) begin
            r_phase   <= '0;
            r_prechrg <= 1'b1;
            if (en_i) begin
              r_state <= S_PRE;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
            // Illegal and incomplete in one sample still count as a single error event.
            if (w_illegal || w_incomplete) begin
              r_err_illegal    <= w_illegal;
              r_err_incomplete <= w_incomplete;
              r_err_cnt        <= sat_inc(r_err_cnt);
            end else begin
              r_data  <= rail_t_i;
              r_valid <= 1'b1;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_phase   <= '0;
          r_prechrg <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign prechrg_o        = r_prechrg;
  assign busy_o           = r_busy;
  assign data_o           = r_data;
  assign valid_o          = r_valid;
  assign err_illegal_o    = r_err_illegal;
  assign err_incomplete_o = r_err_incomplete;
  assign err_spacer_o     = r_err_spacer;
  assign err_cnt_o        = r_err_cnt;

endmodule

// File: tb/tb_wddl_capture.sv
// Bench for wddl_capture: table of precharge/evaluate windows feeding a scoreboard of
// expected output pulses, plus hand-written reset, saturation and stop sequences.
module tb_wddl_capture;

  localparam int WIDTH    = 8;
  localparam int PRE_CYC  = 1;
  localparam int EVAL_CYC = 2;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic [WIDTH-1:0] rail_t_i;
  logic [WIDTH-1:0] rail_f_i;
  logic             prechrg_o;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             err_illegal_o;
  logic             err_incomplete_o;
  logic             err_spacer_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic             busy_o;

  wddl_capture #(
    .WIDTH(WIDTH), .PRE_CYC(PRE_CYC), .EVAL_CYC(EVAL_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .rail_t_i(rail_t_i), .rail_f_i(rail_f_i),
    .prechrg_o(prechrg_o), .data_o(data_o), .valid_o(valid_o),
    .err_illegal_o(err_illegal_o), .err_incomplete_o(err_incomplete_o),
    .err_spacer_o(err_spacer_o), .err_cnt_o(err_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // One precharge/evaluate window: rails in each phase, en_i during evaluate, expected sample result.
  typedef struct {
    logic [7:0] tp;
    logic [7:0] fp;
    logic [7:0] te;
    logic [7:0] fe;
    bit         en_ev;
    bit         spc;
    bit         vld;
    bit         ill;
    bit         inc;
    logic [7:0] data;
  } vec_t;

  typedef struct {
    int         cyc;
    bit         spc;
    bit         vld;
    bit         ill;
    bit         inc;
    logic [7:0] data;
    logic [7:0] cnt;
  } ev_t;

  ev_t        sb[$];
  vec_t       tbl[9];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [7:0] cnt_m = 8'h00;
  logic [7:0] data_m = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'h01;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // Called #1 after the edge that put the DUT into PRE; returns #1 after the sampling edge.
  task automatic run_window(input vec_t v);
    int c0;
    ev_t e;
    c0 = cyc;
    rail_t_i = v.tp;
    rail_f_i = v.fp;
    chk1("prechrg_in_pre", prechrg_o, 1'b1);
    chk1("busy_in_pre", busy_o, 1'b1);
    if (v.spc) begin
      cnt_m = sat8(cnt_m);
      e = '{cyc: c0 + PRE_CYC, spc: 1'b1, vld: 1'b0, ill: 1'b0, inc: 1'b0,
            data: data_m, cnt: cnt_m};
      sb.push_back(e);
    end
    if (v.ill || v.inc) cnt_m = sat8(cnt_m);
    data_m = v.data;
    e = '{cyc: c0 + PRE_CYC + EVAL_CYC, spc: 1'b0, vld: v.vld, ill: v.ill, inc: v.inc,
          data: v.data, cnt: cnt_m};
    sb.push_back(e);
    repeat (PRE_CYC) @(posedge clk);
    #1;
    chk1("prechrg_in_eval", prechrg_o, 1'b0);
    rail_t_i = v.te;
    rail_f_i = v.fe;
    en_i     = v.en_ev;
    repeat (EVAL_CYC) @(posedge clk);
    #1;
  endtask

  // Any output pulse must match the oldest expected event, including the cycle it lands in.
  always @(negedge clk) begin
    if (mon_en && (valid_o === 1'b1 || err_illegal_o === 1'b1 ||
                   err_incomplete_o === 1'b1 || err_spacer_o === 1'b1)) begin
      ev_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: cyc=%0d v=%b ill=%b inc=%b spc=%b, none expected",
                 cyc, valid_o, err_illegal_o, err_incomplete_o, err_spacer_o);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || valid_o !== e.vld || err_illegal_o !== e.ill ||
            err_incomplete_o !== e.inc || err_spacer_o !== e.spc ||
            data_o !== e.data || err_cnt_o !== e.cnt) begin
          n_err++;
          $display("FAIL event: got cyc=%0d v=%b ill=%b inc=%b spc=%b data=%02h cnt=%02h expected cyc=%0d v=%b ill=%b inc=%b spc=%b data=%02h cnt=%02h",
                   cyc, valid_o, err_illegal_o, err_incomplete_o, err_spacer_o, data_o, err_cnt_o,
                   e.cyc, e.vld, e.ill, e.inc, e.spc, e.data, e.cnt);
        end
      end
    end
  end

  initial begin
    vec_t v;
    //             tp     fp     te     fe     en  spc vld ill inc data
    tbl[0] = '{8'h00, 8'h00, 8'hA5, 8'h5A, 1'b1, 0, 1, 0, 0, 8'hA5};
    tbl[1] = '{8'h00, 8'h00, 8'hA5, 8'h5A, 1'b1, 0, 1, 0, 0, 8'hA5};
    tbl[2] = '{8'h00, 8'h00, 8'hFF, 8'h01, 1'b1, 0, 0, 1, 0, 8'hA5};
    tbl[3] = '{8'h01, 8'h00, 8'h0F, 8'h70, 1'b1, 1, 0, 0, 1, 8'hA5};
    tbl[4] = '{8'h00, 8'h00, 8'h3C, 8'hC3, 1'b1, 0, 1, 0, 0, 8'h3C};
    tbl[5] = '{8'h00, 8'h80, 8'hF0, 8'h0F, 1'b1, 1, 1, 0, 0, 8'hF0};
    tbl[6] = '{8'h00, 8'h00, 8'h03, 8'h01, 1'b1, 0, 0, 1, 1, 8'hF0};
    tbl[7] = '{8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, 0, 1, 0, 0, 8'h00};
    tbl[8] = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 0, 1, 0, 0, 8'hFF};

    rst_i = 1'b1;
    en_i = 1'b0;
    rail_t_i = 8'h00;
    rail_f_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_prechrg", prechrg_o, 1'b1);
    chk8("rst_data", data_o, 8'h00);
    chk8("rst_cnt", err_cnt_o, 8'h00);
    chk1("rst_valid", valid_o, 1'b0);
    chk1("rst_illegal", err_illegal_o, 1'b0);
    chk1("rst_incomplete", err_incomplete_o, 1'b0);
    chk1("rst_spacer", err_spacer_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    mon_en = 1'b1;

    // Idle with en_i low must stay idle.
    repeat (2) @(posedge clk);
    #1;
    chk1("idle_hold_busy", busy_o, 1'b0);

    en_i = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) run_window(tbl[i]);

    // Hammer the counter with illegal words well past its saturation point.
    for (int i = 0; i < 300; i++) begin
      v = '{8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 0, 0, 1, 0, data_m};
      run_window(v);
    end
    chk8("cnt_saturated", err_cnt_o, 8'hFF);

    // en_i drops mid-evaluate: the pair still completes, then the FSM parks in IDLE.
    v = '{8'h00, 8'h00, 8'h69, 8'h96, 1'b0, 0, 1, 0, 0, 8'h69};
    run_window(v);
    chk1("stop_busy", busy_o, 1'b0);
    chk1("stop_prechrg", prechrg_o, 1'b1);
    @(posedge clk);
    #1;
    chk1("stop_stays_idle", busy_o, 1'b0);
    chk8("stop_data_hold", data_o, 8'h69);

    // Reset on the last evaluate edge with legal rails: the sample must be discarded.
    en_i = 1'b1;
    @(posedge clk);
    #1;
    rail_t_i = 8'h00;
    rail_f_i = 8'h00;
    @(posedge clk);
    #1;
    rail_t_i = 8'h55;
    rail_f_i = 8'hAA;
    en_i = 1'b0;
    @(posedge clk);
    #1;
    chk1("mid_eval_prechrg", prechrg_o, 1'b0);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk1("rst_eval_valid", valid_o, 1'b0);
    chk8("rst_eval_data", data_o, 8'h00);
    chk1("rst_eval_busy", busy_o, 1'b0);
    chk1("rst_eval_prechrg", prechrg_o, 1'b1);
    chk8("rst_eval_cnt", err_cnt_o, 8'h00);
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("post_rst_idle", busy_o, 1'b0);
    chk8("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
